// File: rtl/count_uart_tx_pkg.sv
// Shared types and constants for the counter-snapshot UART transmitter.
package count_uart_tx_pkg;

  localparam int   DATA_BITS  = 8;
  localparam int   BIT_IDX_W  = $clog2(DATA_BITS);
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/count_uart_tx_baud_tick_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses o_tick on the terminal count.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = i_en & ~i_clear & (r_cnt == TERMINAL);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/count_uart_tx.sv
// Captures an 8-bit counter snapshot (handshake or on change) and sends it as a UART frame.
module count_uart_tx
  import count_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [DATA_BITS-1:0] value_in,
  input  logic                 value_valid,
  output logic                 value_ready,
  input  logic                 auto_en,
  output logic                 tx_out,
  output logic                 busy,
  output logic [7:0]           frames_sent
);

  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

  uart_state_e          r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [BIT_IDX_W-1:0] r_bit_idx;
  logic                 r_parity;
  logic [DATA_BITS-1:0] r_last_sent;
  logic                 r_tx;
  logic                 r_busy;
  logic [7:0]           r_frames;

  uart_state_e          w_state_next;
  logic [DATA_BITS-1:0] w_shift_next;
  logic [BIT_IDX_W-1:0] w_bit_idx_next;
  logic                 w_parity_next;
  logic                 w_tx_next;
  logic [7:0]           w_frames_next;
  logic                 w_tick;
  logic                 w_capture;
  logic                 w_idle;

  assign w_idle = (r_state == ST_IDLE);

  // The timer is held at zero while idle so START always gets a full bit period.
  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (ena),
    .i_clear(w_idle),
    .o_tick (w_tick)
  );

  assign value_ready = ~r_busy & ena;
  assign w_capture   = w_idle & ((value_valid & value_ready) |
                                 (auto_en & ena & (value_in != r_last_sent)));

  // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_idx_next = r_bit_idx;
    w_parity_next  = r_parity;
    w_frames_next  = r_frames;

    case (r_state)
      ST_IDLE: begin
        if (w_capture) begin
          w_state_next   = ST_START;
          w_shift_next   = value_in;
          w_bit_idx_next = '0;
          w_parity_next  = even_parity(value_in);
        end
      end
      ST_START: begin
        if (w_tick) w_state_next = ST_DATA;
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_bit_idx == LAST_BIT) begin
            w_state_next = PARITY_EN ? ST_PARITY : ST_STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + BIT_IDX_W'(1);
            w_shift_next   = r_shift >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (w_tick) w_state_next = ST_STOP;
      end
      ST_STOP: begin
        if (w_tick) begin
          w_state_next  = ST_IDLE;
          w_frames_next = r_frames + 8'd1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    // Line level is derived from the upcoming state so tx_out leaves a flop.
    case (w_state_next)
      ST_START:  w_tx_next = 1'b0;
      ST_DATA:   w_tx_next = w_shift_next[0];
      ST_PARITY: w_tx_next = w_parity_next;
      default:   w_tx_next = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_parity    <= 1'b0;
      r_last_sent <= '0;
      r_tx        <= IDLE_LEVEL;
      r_busy      <= 1'b0;
      r_frames    <= '0;
    end else if (ena) begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_idx <= w_bit_idx_next;
      r_parity  <= w_parity_next;
      r_tx      <= w_tx_next;
      r_busy    <= (w_state_next != ST_IDLE);
      r_frames  <= w_frames_next;
      if (w_capture) r_last_sent <= value_in;
    end
  end

  assign tx_out      = r_tx;
  assign busy        = r_busy;
  assign frames_sent = r_frames;

endmodule
